// File: rtl/audio_delay_ram_ctrl_pkg.sv
// Shared types and default sizes for the audio delay-line RAM controller.
package audio_buf_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int RD_LATENCY_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/audio_delay_ram_ctrl_if.sv
// Sample stream and RAM port bundle; master is the controller side.
interface audio_delay_ram_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  ram_wr_en;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    modport master (
        input  in_valid, in_data, ram_rd_data,
        output in_ready, out_valid, out_data,
        output ram_addr, ram_wr_data, ram_wr_en
    );

    modport slave (
        output in_valid, in_data, ram_rd_data,
        input  in_ready, out_valid, out_data,
        input  ram_addr, ram_wr_data, ram_wr_en
    );
endinterface

// File: rtl/audio_delay_ram_ctrl.sv
// Audio delay line over a single-port sample RAM: read the sample DELAY
// entries back, then write the new one at the write pointer.
module audio_delay_ram_ctrl
    import audio_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] delay,
    audio_delay_ram_ctrl_if.master bus
);
    localparam int WAITS = RD_LATENCY - 1;
    localparam int CW    = $clog2(RD_LATENCY) + 1;
    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state;
    logic [CW-1:0]         wait_cnt;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH:0]   fill;
    logic [ADDR_WIDTH-1:0] delay_l;
    logic [DATA_WIDTH-1:0] sample_l;
    logic [ADDR_WIDTH:0]   delay_eff;
    logic                  go_write;

    // A latched delay of zero stands for the full buffer depth.
    assign delay_eff = {(delay_l == '0), delay_l};

    assign go_write = (state == WAIT && wait_cnt == '0) ||
                      (state == READ && WAITS == 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            wptr            <= '0;
            fill            <= '0;
            delay_l         <= '0;
            sample_l        <= '0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.ram_addr    <= '0;
            bus.ram_wr_data <= '0;
            bus.ram_wr_en   <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            wptr          <= '0;
            fill          <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.ram_wr_en <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        sample_l      <= bus.in_data;
                        delay_l       <= delay;
                        bus.ram_addr  <= wptr - delay;
                        bus.ram_wr_en <= 1'b0;
                        bus.in_ready  <= 1'b0;
                        state         <= READ;
                    end
                end
                READ: begin
                    wait_cnt <= CW'(WAITS - 1);
                    state    <= (WAITS == 0) ? WRITE : WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) state <= WRITE;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                WRITE: begin
                    // Unwritten or stale slots read back as silence.
                    bus.out_data  <= (fill >= delay_eff) ? bus.ram_rd_data : '0;
                    bus.out_valid <= 1'b1;
                    bus.ram_wr_en <= 1'b0;
                    state         <= DONE;
                end
                DONE: begin
                    wptr         <= wptr + 1'b1;
                    fill         <= (fill == FULL) ? fill : fill + 1'b1;
                    bus.in_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (go_write) begin
                bus.ram_addr    <= wptr;
                bus.ram_wr_data <= sample_l;
                bus.ram_wr_en   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_delay_ram_ctrl.sv
// Scoreboard bench for audio_delay_ram_ctrl with a 2-cycle behavioural RAM.
module tb_audio_delay_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [9:0] delay = '0;

    audio_delay_ram_ctrl_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus ();

    audio_delay_ram_ctrl #(
        .ADDR_WIDTH(10), .DATA_WIDTH(16), .RD_LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .delay(delay), .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: address sampled on an edge, data out two edges on.
    logic [15:0] mem [1024];
    logic [15:0] stage1;
    initial for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    always @(posedge clk) begin
        if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wr_data;
        stage1          <= mem[bus.ram_addr];
        bus.ram_rd_data <= stage1;
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc = -1;
    int wr_run = 0;

    // Reference: plain history of samples written since the last clear.
    int hist[$];
    int exp_q[$];
    int wa_q[$];
    int wd_q[$];
    int wcnt = 0;

    always @(negedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        exp_q.delete();
        wa_q.delete();
        wd_q.delete();
        wcnt = 0;
    endtask

    task automatic model_accept(input int d, input int dl);
        int deff;
        int e;
        deff = (dl == 0) ? 1024 : dl;
        e = (hist.size() >= deff) ? hist[hist.size() - deff] : 0;
        exp_q.push_back(e);
        wa_q.push_back(wcnt % 1024);
        wd_q.push_back(d);
        hist.push_back(d);
        if (hist.size() > 1024) void'(hist.pop_front());
        wcnt++;
    endtask

    // Output monitor.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_valid: got out_data=0x%0h expected no output",
                         bus.out_data);
            end else begin
                chk("out_data", int'(bus.out_data), exp_q.pop_front());
            end
        end
    end

    // RAM write monitor: one-cycle pulses with the expected address/data.
    always @(negedge clk) begin
        if (!rst && bus.ram_wr_en) begin
            wr_run++;
            if (wr_run > 1) begin
                chk("wr_en_pulse_len", wr_run, 1);
            end else if (wa_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr=%0d expected no write",
                         bus.ram_addr);
            end else begin
                chk("wr_addr", int'(bus.ram_addr), wa_q.pop_front());
                chk("wr_data", int'(bus.ram_wr_data), wd_q.pop_front());
            end
        end else begin
            wr_run = 0;
        end
    end

    task automatic send(input int d, input int dl, input bit hold, input bit gap_chk);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'(d);
        delay        = 10'(dl);
        @(posedge clk);
        model_accept(d & 16'hFFFF, dl);
        if (gap_chk && last_acc >= 0) chk("accept_gap", cyc - last_acc, 5);
        last_acc = cyc;
        #1;
        delay = 10'($urandom);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        model_clear();
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},    int'(bus.in_ready), 1);
        chk({tag, "_out_valid"},   int'(bus.out_valid), 0);
        chk({tag, "_out_data"},    int'(bus.out_data), 0);
        chk({tag, "_ram_addr"},    int'(bus.ram_addr), 0);
        chk({tag, "_ram_wr_data"}, int'(bus.ram_wr_data), 0);
        chk({tag, "_ram_wr_en"},   int'(bus.ram_wr_en), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wa_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_out_pending", exp_q.size(), 0);
        chk("drain_wr_pending", wa_q.size(), 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Delay 3 over a short ramp.
        last_acc = -1;
        for (int i = 1; i <= 6; i++) send(i, 3, 1'b0, 1'b1);
        drain();

        // Full-scale extremes through a one-sample delay.
        last_acc = -1;
        send(16'h7FFF, 1, 1'b0, 1'b0);
        send(16'h8000, 1, 1'b0, 1'b0);
        drain();

        // Delay 0 is the full 1024-entry buffer, including wrap-around.
        do_flush();
        for (int i = 0; i <= 1024; i++) send(i, 0, 1'b0, 1'b0);
        send(16'h1234, 5, 1'b0, 1'b0);
        drain();

        // Flush while the eleventh op sits in WAIT.
        do_flush();
        for (int i = 0; i < 10; i++) send(100 + i, 3, 1'b0, 1'b0);
        send(16'hBEEF, 3, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        model_clear();
        @(negedge clk);
        flush = 1'b0;
        send(16'h0AAA, 2, 1'b0, 1'b0);
        send(16'h0BBB, 2, 1'b0, 1'b0);
        send(16'h0CCC, 2, 1'b0, 1'b0);
        drain();

        // Asynchronous reset during WRITE.
        send(16'h5555, 1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("wr_en_in_write", int'(bus.ram_wr_en), 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        send(16'h0777, 1, 1'b0, 1'b0);
        send(16'h0888, 1, 1'b0, 1'b0);
        drain();

        // in_valid held high continuously.
        last_acc = -1;
        for (int i = 0; i < 20; i++) send(16'(1000 + 7 * i), 2, 1'b1, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain();

        // Randomised traffic with idle gaps and occasional flushes.
        for (int i = 0; i < 200; i++) begin
            int dl;
            dl = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 12));
            send(int'($urandom_range(0, 65535)), dl, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                drain();
                do_flush();
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
